// File: rtl/mem_access_unit.sv
// Load/store stage between execute and write-back: decodes the access,
// runs a req/ready handshake to data memory and returns the write-back value.
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] alu_res,
    input  logic [31:0] store_data,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] wb_data,
    output logic        err
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       funct3_q;
    logic [1:0]       lo_q;
    logic             is_read_q;

    logic             illegal_c;
    logic             misaligned_c;
    logic [31:0]      wdata_c;
    logic [3:0]       wstrb_c;
    logic             timeout_c;

    // Select and extend the addressed lane of a read word.
    function automatic logic [31:0] load_extract(input logic [2:0]  f3,
                                                 input logic [1:0]  lo,
                                                 input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        b = rdata[{lo, 3'b000} +: 8];
        h = rdata[{lo[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'd0, b};
            3'b101:  return {16'd0, h};
            default: return rdata;
        endcase
    endfunction

    // Decode legality, alignment and store lane placement of the incoming request.
    always_comb begin
        illegal_c    = 1'b0;
        misaligned_c = 1'b0;
        wdata_c      = store_data;
        wstrb_c      = 4'hF;
        if (mem_read && !mem_write) begin
            illegal_c = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        end else if (mem_write && !mem_read) begin
            illegal_c = (funct3[2] == 1'b1) || (funct3[1:0] == 2'b11);
        end
        case (funct3[1:0])
            2'b00: begin
                wdata_c = {4{store_data[7:0]}};
                wstrb_c = 4'b0001 << alu_res[1:0];
            end
            2'b01: begin
                misaligned_c = alu_res[0];
                wdata_c      = {2{store_data[15:0]}};
                wstrb_c      = 4'b0011 << {alu_res[1], 1'b0};
            end
            2'b10: begin
                misaligned_c = (alu_res[1:0] != 2'b00);
            end
            default: ;
        endcase
    end

    // Timeout fires on the last allowed wait cycle; a ready on that cycle still wins.
    always_comb begin
        timeout_c = (TIMEOUT_CYCLES != 0) && (32'(cnt) == TIMEOUT_CYCLES - 32'd1);
    end

    // Access FSM with registered bus and result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            funct3_q   <= 3'd0;
            lo_q       <= 2'd0;
            is_read_q  <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 32'd0;
            dmem_wdata <= 32'd0;
            dmem_wstrb <= 4'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            wb_data    <= 32'd0;
            err        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (in_valid) begin
                        funct3_q  <= funct3;
                        lo_q      <= alu_res[1:0];
                        is_read_q <= mem_read;
                        if (!mem_read && !mem_write) begin
                            state   <= S_RESP;
                            done    <= 1'b1;
                            wb_data <= alu_res;
                            err     <= 1'b0;
                        end else if ((mem_read && mem_write) || illegal_c || misaligned_c) begin
                            state   <= S_RESP;
                            done    <= 1'b1;
                            wb_data <= 32'd0;
                            err     <= 1'b1;
                        end else begin
                            state      <= S_ACCESS;
                            cnt        <= '0;
                            busy       <= 1'b1;
                            dmem_req   <= 1'b1;
                            dmem_we    <= mem_write;
                            dmem_addr  <= {alu_res[31:2], 2'b00};
                            dmem_wdata <= mem_write ? wdata_c : 32'd0;
                            dmem_wstrb <= mem_write ? wstrb_c : 4'd0;
                        end
                    end
                end
                S_ACCESS: begin
                    if (dmem_ready || timeout_c) begin
                        state      <= S_RESP;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        dmem_req   <= 1'b0;
                        dmem_we    <= 1'b0;
                        dmem_wstrb <= 4'd0;
                        err        <= !dmem_ready;
                        wb_data    <= (dmem_ready && is_read_q)
                                      ? load_extract(funct3_q, lo_q, dmem_rdata) : 32'd0;
                    end else if (TIMEOUT_CYCLES != 0) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_RESP: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small reactive memory responder.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] alu_res = 32'd0;
    logic [31:0] store_data = 32'd0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ready = 1'b0;
    logic [31:0] dmem_rdata = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] wb_data;
    logic        err;

    int tests_run = 0;
    int tests_failed = 0;

    // Results of the last run_op call
    int          r_done_cyc;
    int          r_req_cyc;
    logic        r_busy1;
    logic        r_busy_done;
    logic [31:0] r_wb;
    logic        r_err;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_we;

    mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .alu_res(alu_res),
        .store_data(store_data), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata), .busy(busy),
        .done(done), .wb_data(wb_data), .err(err)
    );

    always #5 clk = ~clk;

    // Issue one op; ready_after = number of req cycles before ready (-1 = never).
    task automatic run_op(input logic [31:0] a, input logic [31:0] sd,
                          input logic rd, input logic wr, input logic [2:0] f3,
                          input int ready_after, input logic [31:0] rdata);
        @(negedge clk);
        alu_res = a; store_data = sd; mem_read = rd; mem_write = wr; funct3 = f3;
        in_valid = 1'b1;
        r_done_cyc = -1; r_req_cyc = 0; r_busy1 = 1'b0; r_busy_done = 1'b1;
        r_wb = 32'hX; r_err = 1'bX; r_addr = 32'd0; r_wdata = 32'd0; r_wstrb = 4'd0; r_we = 1'b0;
        @(negedge clk);
        in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        r_busy1 = busy;
        for (int i = 1; i <= 40; i++) begin
            if (done) begin
                r_done_cyc = i; r_wb = wb_data; r_err = err; r_busy_done = busy;
                dmem_ready = 1'b0;
                break;
            end
            if (dmem_req) begin
                if (r_req_cyc == 0) begin
                    r_addr = dmem_addr; r_wdata = dmem_wdata; r_wstrb = dmem_wstrb; r_we = dmem_we;
                end
                r_req_cyc++;
                if (ready_after >= 0 && r_req_cyc == ready_after + 1) begin
                    dmem_ready = 1'b1; dmem_rdata = rdata;
                end
            end else begin
                dmem_ready = 1'b0;
            end
            @(negedge clk);
        end
        dmem_ready = 1'b0;
        tests_run++;
        if (r_done_cyc < 0) begin
            tests_failed++;
            $display("FAIL op_no_done addr=%h got no done within 40 cycles, required done", a);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({dmem_req, dmem_we, busy, done, err} !== 5'b0 || wb_data !== 32'd0
            || dmem_addr !== 32'd0 || dmem_wstrb !== 4'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs got req=%b we=%b busy=%b done=%b err=%b wb=%h addr=%h strb=%h, required all 0",
                     dmem_req, dmem_we, busy, done, err, wb_data, dmem_addr, dmem_wstrb);
        end
        rst = 1'b0;
    endtask

    task automatic test_lw();
        run_op(32'h100, 32'd0, 1'b1, 1'b0, 3'b010, 2, 32'hDEADBEEF);
        tests_run++;
        if (r_addr !== 32'h100 || r_we !== 1'b0 || r_wstrb !== 4'h0) begin
            tests_failed++;
            $display("FAIL lw_bus got addr=%h we=%b strb=%h, required addr=00000100 we=0 strb=0", r_addr, r_we, r_wstrb);
        end
        tests_run++;
        if (r_done_cyc !== 4 || r_req_cyc !== 3) begin
            tests_failed++;
            $display("FAIL lw_latency got done_cyc=%0d req_cyc=%0d, required 4 and 3", r_done_cyc, r_req_cyc);
        end
        tests_run++;
        if (r_wb !== 32'hDEADBEEF || r_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL lw_result got wb=%h err=%b, required deadbeef err=0", r_wb, r_err);
        end
        tests_run++;
        if (r_busy1 !== 1'b1 || r_busy_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL lw_busy got busy_first=%b busy_at_done=%b, required 1 and 0", r_busy1, r_busy_done);
        end
        @(negedge clk);
        tests_run++;
        if (done !== 1'b0 || wb_data !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL lw_done_pulse got done=%b wb=%h after pulse, required done=0 wb held deadbeef", done, wb_data);
        end
    endtask

    task automatic test_load_lanes();
        logic [2:0]  f3s [4] = '{3'b000, 3'b100, 3'b101, 3'b001};
        logic [31:0] adr [4] = '{32'h103, 32'h103, 32'h102, 32'h102};
        logic [31:0] exp [4] = '{32'hFFFFFF80, 32'h00000080, 32'h00008011, 32'hFFFF8011};
        for (int i = 0; i < 4; i++) begin
            run_op(adr[i], 32'd0, 1'b1, 1'b0, f3s[i], 0, 32'h80112233);
            tests_run++;
            if (r_wb !== exp[i] || r_err !== 1'b0 || r_addr !== 32'h100) begin
                tests_failed++;
                $display("FAIL load_lane_%0d got wb=%h err=%b addr=%h, required wb=%h err=0 addr=00000100",
                         i, r_wb, r_err, r_addr, exp[i]);
            end
        end
    endtask

    task automatic test_stores();
        logic [2:0]  f3s [3] = '{3'b001, 3'b000, 3'b010};
        logic [31:0] adr [3] = '{32'h206, 32'h201, 32'h208};
        logic [31:0] sd  [3] = '{32'h0000ABCD, 32'h1234565A, 32'hCAFEF00D};
        logic [31:0] ewd [3] = '{32'hABCDABCD, 32'h5A5A5A5A, 32'hCAFEF00D};
        logic [3:0]  est [3] = '{4'b1100, 4'b0010, 4'b1111};
        logic [31:0] ead [3] = '{32'h204, 32'h200, 32'h208};
        for (int i = 0; i < 3; i++) begin
            run_op(adr[i], sd[i], 1'b0, 1'b1, f3s[i], 1, 32'hFFFFFFFF);
            tests_run++;
            if (r_wdata !== ewd[i] || r_wstrb !== est[i] || r_we !== 1'b1 || r_addr !== ead[i]) begin
                tests_failed++;
                $display("FAIL store_bus_%0d got wdata=%h strb=%b we=%b addr=%h, required wdata=%h strb=%b we=1 addr=%h",
                         i, r_wdata, r_wstrb, r_we, r_addr, ewd[i], est[i], ead[i]);
            end
            tests_run++;
            if (r_wb !== 32'd0 || r_err !== 1'b0 || r_done_cyc !== 3) begin
                tests_failed++;
                $display("FAIL store_resp_%0d got wb=%h err=%b done_cyc=%0d, required wb=0 err=0 done_cyc=3",
                         i, r_wb, r_err, r_done_cyc);
            end
        end
    endtask

    task automatic test_no_bus();
        run_op(32'h12345678, 32'd0, 1'b0, 1'b0, 3'b000, -1, 32'd0);
        tests_run++;
        if (r_wb !== 32'h12345678 || r_err !== 1'b0 || r_done_cyc !== 1 || r_req_cyc !== 0 || r_busy1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL passthrough got wb=%h err=%b done_cyc=%0d req_cyc=%0d busy=%b, required 12345678 0 1 0 0",
                     r_wb, r_err, r_done_cyc, r_req_cyc, r_busy1);
        end
    endtask

    task automatic test_errors();
        logic [31:0] adr [5] = '{32'h101, 32'h100, 32'h100, 32'h100, 32'h101};
        logic        rds [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic        wrs [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [2:0]  f3s [5] = '{3'b010, 3'b010, 3'b011, 3'b011, 3'b001};
        for (int i = 0; i < 5; i++) begin
            run_op(adr[i], 32'h55, rds[i], wrs[i], f3s[i], 0, 32'h11111111);
            tests_run++;
            if (r_err !== 1'b1 || r_done_cyc !== 1 || r_req_cyc !== 0) begin
                tests_failed++;
                $display("FAIL error_case_%0d got err=%b done_cyc=%0d req_cyc=%0d, required err=1 done_cyc=1 req_cyc=0",
                         i, r_err, r_done_cyc, r_req_cyc);
            end
        end
    endtask

    task automatic test_timeout();
        run_op(32'h300, 32'd0, 1'b1, 1'b0, 3'b010, 0, 32'h77777777);
        run_op(32'h300, 32'd0, 1'b1, 1'b0, 3'b010, -1, 32'd0);
        tests_run++;
        if (r_req_cyc !== 4 || r_done_cyc !== 5 || r_err !== 1'b1 || r_wb !== 32'd0) begin
            tests_failed++;
            $display("FAIL timeout got req_cyc=%0d done_cyc=%0d err=%b wb=%h, required 4 5 1 00000000",
                     r_req_cyc, r_done_cyc, r_err, r_wb);
        end
        run_op(32'h304, 32'd0, 1'b1, 1'b0, 3'b010, 3, 32'h0BADCAFE);
        tests_run++;
        if (r_req_cyc !== 4 || r_err !== 1'b0 || r_wb !== 32'h0BADCAFE) begin
            tests_failed++;
            $display("FAIL ready_on_timeout got req_cyc=%0d err=%b wb=%h, required 4 0 0badcafe",
                     r_req_cyc, r_err, r_wb);
        end
    endtask

    task automatic test_reset_mid_access();
        @(negedge clk);
        alu_res = 32'h400; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; mem_read = 1'b0;
        tests_run++;
        if (dmem_req !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_access_req got req=%b, required 1", dmem_req);
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if (dmem_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset got req=%b busy=%b done=%b, required 0 0 0", dmem_req, busy, done);
        end
        @(negedge clk);
        rst = 1'b0;
        run_op(32'h408, 32'd0, 1'b1, 1'b0, 3'b010, 1, 32'h600DF00D);
        tests_run++;
        if (r_wb !== 32'h600DF00D || r_err !== 1'b0 || r_addr !== 32'h408) begin
            tests_failed++;
            $display("FAIL after_reset got wb=%h err=%b addr=%h, required 600df00d 0 00000408", r_wb, r_err, r_addr);
        end
    endtask

    task automatic test_ignore_in_valid_busy();
        // A second strobe during ACCESS must not disturb the first access.
        @(negedge clk);
        alu_res = 32'h500; mem_read = 1'b1; funct3 = 3'b010; in_valid = 1'b1;
        @(negedge clk);
        alu_res = 32'h0; mem_read = 1'b0; mem_write = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        dmem_ready = 1'b1; dmem_rdata = 32'hA5A5A5A5;
        @(negedge clk);
        dmem_ready = 1'b0;
        tests_run++;
        if (done !== 1'b1 || wb_data !== 32'hA5A5A5A5 || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL ignore_in_valid got done=%b wb=%h err=%b, required 1 a5a5a5a5 0", done, wb_data, err);
        end
        @(negedge clk);
        tests_run++;
        if (done !== 1'b0 || dmem_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL ignore_in_valid_idle got done=%b req=%b, required 0 0", done, dmem_req);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_load_lanes();
        test_stores();
        test_no_bus();
        test_errors();
        test_timeout();
        test_reset_mid_access();
        test_ignore_in_valid_busy();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
